lsu_mem_access: RTL and testbench
=================================

Name: lsu_mem_access

Overview:
- Load/store execution unit on the consumer side of the funct3 load/store type decode.
- Takes the one-hot load, unsigned-load and store type vectors plus an address and store data from the memory stage.
- Performs the access on a word-wide data-memory request/grant/response interface, with byte enables and lane steering, and returns sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access is aborted with a fault. Minimum 2.
- CNT_W, 8: width of the timeout counter. Must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iValid  input  1  memory-stage instruction valid.
- iLoad  input  1  instruction is a load.
- iStore  input  1  instruction is a store.
- iLoadTypeBHW  input  3  one-hot {byte, half, word} signed load.
- iULoadTypeBH  input  2  one-hot {unsigned byte, unsigned half} load.
- iStoreTypeBHW  input  3  one-hot {byte, half, word} store.
- iAddr  input  32  byte address.
- iWdata  input  32  store data; low bits are significant.
- oBusy  output  1  stall request to the pipeline (combinational).
- oDone  output  1  one-cycle completion pulse.
- oRdata  output  32  extended load result; held until the next accept.
- oMisaligned  output  1  fault qualifier, valid with oDone.
- oFault  output  1  timeout or illegal-type qualifier, valid with oDone.
- oMemReq  output  1  memory request.
- oMemWe  output  1  write enable.
- oMemAddr  output  32  word address, {iAddr[31:2], 2'b00}.
- oMemBe  output  4  byte enables.
- oMemWdata  output  32  lane-steered store data.
- iMemGnt  input  1  request accepted this cycle.
- iMemRvalid  input  1  read data valid.
- iMemRdata  input  32  read data.

Behaviour:
- Reset, asynchronous while iRst=1:
  - state=IDLE, timeout counter=0.
  - oRdata=0; oDone, oMisaligned, oFault, oMemReq, oMemWe all 0; oMemBe=0; oMemAddr=0; oMemWdata=0.
  - Reset mid-access abandons the access silently; a late iMemRvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, RESP.
- Accept: in IDLE, iValid & (iLoad | iStore).
  - Operation type: exactly one bit set across the five load bits (loads) or across iStoreTypeBHW (stores).
  - iLoad & iStore together, or a non-one-hot type vector, is illegal -> RESP with oFault=1 and no memory request.
- Alignment check:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - Misaligned -> RESP with oMisaligned=1 and no memory request.
- Legal, aligned accept:
  - Register the address, type and lane info.
  - Go to REQ; oMemReq is asserted from the next cycle.
- REQ: oMemReq=1, with oMemWe, oMemAddr, oMemBe and oMemWdata held stable until iMemGnt.
  - On gnt, a store goes to RESP.
  - On gnt, a load goes to WAIT.
  - iMemRvalid coinciding with gnt is accepted, and the load goes directly to RESP.
- WAIT: on iMemRvalid, capture and extend the data, then go to RESP.
- RESP: oDone=1 for exactly one cycle, then IDLE. oMisaligned and oFault are valid only in this cycle.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1], 1'b0}.
  - Word: 4'b1111.
  - Loads drive oMemBe=1111 and oMemWe=0.
- Store data:
  - Byte: iWdata[7:0] replicated on all 4 lanes.
  - Half: iWdata[15:0] replicated on both halves.
  - Word: iWdata unchanged.
- Load data:
  - Select the lane from addr[1:0].
  - Signed types sign-extend bit 7 or bit 15; unsigned types zero-extend; word is passed through.
  - oRdata updates only on a successful load. It is unchanged after stores and faults.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ or WAIT.
  - When the counter equals TIMEOUT_CYCLES-1 without the awaited gnt or rvalid, go to RESP with oFault=1 and drop oMemReq.
- oBusy is combinational:
  - (state==REQ) | (state==WAIT) | (state==IDLE & accept).
  - It is 0 in RESP, so the pipeline advances in the oDone cycle.
- In non-IDLE states, iValid and the type inputs are ignored. The pipeline holds them under the stall.

Test Plan:
- LB at addr 0x103, memory returns 0x80FF_0000 -> BE=1111, oRdata=0xFFFF_FF80, oDone one cycle after rvalid.
- LHU at 0x102, rdata 0x9ABC_1234 -> oRdata=0x0000_9ABC. The same access as LH -> 0xFFFF_9ABC.
- SB at 0x101 with iWdata=0x0000_00A5 -> oMemBe=0010, oMemWdata=0xA5A5_A5A5, oMemWe=1; oDone the cycle after gnt; oRdata unchanged.
- SW at 0x102 -> oMisaligned=1 with oDone, no oMemReq ever asserted. LH at 0x101 gives the same result.
- Load with gnt withheld for 300 cycles, TIMEOUT_CYCLES=255 -> oFault=1 with oDone after 255 cycles in REQ, oMemReq drops, oBusy low in the RESP cycle.
- iRst pulsed while in WAIT, then late iMemRvalid -> all outputs 0, state IDLE, the rvalid is ignored. iLoadTypeBHW=3'b110 -> oFault=1, no request.

Source files
------------

// File: rtl/lsu_mem_access.sv
// -----------------------------------------------------------------------------
// lsu_mem_access
//
// Load/store execution unit. Takes the decoded one-hot load/store type vectors
// from the memory stage, performs a single access on a word-wide
// request/grant/response data-memory port, and returns the lane-selected,
// sign- or zero-extended load result. The pipeline is stalled while an access
// is outstanding.
//
// Ports
//   iClk, iRst          clock (rising edge), asynchronous active-high reset
//   iValid              memory-stage instruction valid
//   iLoad / iStore      instruction class
//   iLoadTypeBHW        one-hot {byte, half, word} signed load
//   iULoadTypeBH        one-hot {byte, half} unsigned load
//   iStoreTypeBHW       one-hot {byte, half, word} store
//   iAddr, iWdata       byte address and store data
//   oBusy               combinational stall request
//   oDone               one-cycle completion pulse
//   oRdata              extended load result, held until the next load
//   oMisaligned/oFault  completion qualifiers, valid only with oDone
//   oMemReq/oMemWe/oMemAddr/oMemBe/oMemWdata   memory request channel
//   iMemGnt             request accepted this cycle
//   iMemRvalid/iMemRdata  read response
// -----------------------------------------------------------------------------
module lsu_mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic        iLoad,
  input  logic        iStore,
  input  logic [2:0]  iLoadTypeBHW,
  input  logic [1:0]  iULoadTypeBH,
  input  logic [2:0]  iStoreTypeBHW,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWdata,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oRdata,
  output logic        oMisaligned,
  output logic        oFault,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBe,
  output logic [31:0] oMemWdata,
  input  logic        iMemGnt,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the significant store bits onto every lane they may land in.
  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Select the addressed lane of the returned word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [1:0]  sz,
                                              input logic        uns,
                                              input logic [1:0]  lane,
                                              input logic [31:0] d);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        r;
    sh = d >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      SZ_B: begin
        sx = b;
        r  = uns ? {24'd0, sh[7:0]} : sx;
      end
      SZ_H: begin
        sx = h;
        r  = uns ? {16'd0, sh[15:0]} : sx;
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       sz_q, sz_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             flt_q, flt_d;

  logic             accept;
  logic [1:0]       acc_sz;
  logic             acc_illegal;
  logic             acc_misal;

  // Decode of the incoming request; only meaningful in IDLE.
  always_comb begin
    accept      = (state_q == S_IDLE) & iValid & (iLoad | iStore);
    acc_sz      = SZ_W;
    if (iLoad) begin
      if (iLoadTypeBHW[2] | iULoadTypeBH[1])      acc_sz = SZ_B;
      else if (iLoadTypeBHW[1] | iULoadTypeBH[0]) acc_sz = SZ_H;
      else                                        acc_sz = SZ_W;
    end else begin
      if (iStoreTypeBHW[2])      acc_sz = SZ_B;
      else if (iStoreTypeBHW[1]) acc_sz = SZ_H;
      else                       acc_sz = SZ_W;
    end
    // Load type is one-hot across signed and unsigned vectors combined.
    acc_illegal = (iLoad & iStore)
                | (iLoad  & !$onehot({iLoadTypeBHW, iULoadTypeBH}))
                | (iStore & !$onehot(iStoreTypeBHW));
    acc_misal   = ((acc_sz == SZ_H) & iAddr[0])
                | ((acc_sz == SZ_W) & (|iAddr[1:0]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sz_d    = sz_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          mis_d = 1'b0;
          flt_d = 1'b0;
          if (acc_illegal) begin
            flt_d   = 1'b1;
            state_d = S_RESP;
          end else if (acc_misal) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
            we_d    = iStore;
            sz_d    = acc_sz;
            uns_d   = |iULoadTypeBH;
            lane_d  = iAddr[1:0];
            addr_d  = {iAddr[31:2], 2'b00};
            be_d    = iStore ? byte_en(acc_sz, iAddr[1:0]) : 4'b1111;
            wdata_d = iStore ? steer_wdata(acc_sz, iWdata) : wdata_q;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (iMemGnt) begin
          if (we_q) begin
            state_d = S_RESP;
          end else if (iMemRvalid) begin
            // Zero-latency memory: response arrives with the grant.
            rdata_d = extend_load(sz_q, uns_q, lane_q, iMemRdata);
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          flt_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (iMemRvalid) begin
          rdata_d = extend_load(sz_q, uns_q, lane_q, iMemRdata);
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          flt_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sz_q    <= SZ_B;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sz_q    <= sz_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  // Busy drops in RESP so the pipeline advances together with oDone.
  assign oBusy       = (state_q == S_REQ) | (state_q == S_WAIT) | accept;
  assign oDone       = (state_q == S_RESP);
  assign oMisaligned = oDone & mis_q;
  assign oFault      = oDone & flt_q;
  assign oRdata      = rdata_q;
  assign oMemReq     = (state_q == S_REQ);
  assign oMemWe      = oMemReq & we_q;
  assign oMemAddr    = addr_q;
  assign oMemBe      = be_q;
  assign oMemWdata   = wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

  localparam int TO = 255;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid, iLoad, iStore;
  logic [2:0]  iLoadTypeBHW;
  logic [1:0]  iULoadTypeBH;
  logic [2:0]  iStoreTypeBHW;
  logic [31:0] iAddr, iWdata;
  logic        oBusy, oDone, oMisaligned, oFault;
  logic [31:0] oRdata;
  logic        oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWdata;
  logic [3:0]  oMemBe;
  logic        iMemGnt, iMemRvalid;
  logic [31:0] iMemRdata;

  always #5 iClk = ~iClk;

  lsu_mem_access #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iLoad(iLoad), .iStore(iStore),
    .iLoadTypeBHW(iLoadTypeBHW), .iULoadTypeBH(iULoadTypeBH), .iStoreTypeBHW(iStoreTypeBHW),
    .iAddr(iAddr), .iWdata(iWdata), .oBusy(oBusy), .oDone(oDone), .oRdata(oRdata),
    .oMisaligned(oMisaligned), .oFault(oFault), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemBe(oMemBe), .oMemWdata(oMemWdata), .iMemGnt(iMemGnt),
    .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Observations from one transaction.
  bit          r_done, r_req_seen, r_unstable;
  int          r_cyc, r_reqc;
  logic        r_mis, r_flt, r_busy_acc, r_busy_done, r_req_done, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  // Drive one instruction and play the memory side: grant after gd request
  // cycles, then rvalid after rdl wait cycles (or together with gnt if same).
  task automatic run_access(input logic ld, input logic st, input logic [2:0] lt,
                            input logic [1:0] ut, input logic [2:0] stt,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int gd, input int rdl,
                            input bit same);
    int reqc, waitc;
    bit granted;
    reqc = 0; waitc = 0; granted = 1'b0;
    r_done = 1'b0; r_req_seen = 1'b0; r_unstable = 1'b0; r_cyc = -1;
    @(negedge iClk);
    iValid = 1'b1; iLoad = ld; iStore = st; iLoadTypeBHW = lt; iULoadTypeBH = ut;
    iStoreTypeBHW = stt; iAddr = addr; iWdata = wd;
    #1 r_busy_acc = oBusy;
    for (int c = 0; c < 400; c++) begin
      @(negedge iClk);
      iMemGnt = 1'b0; iMemRvalid = 1'b0; iMemRdata = $urandom;
      if (oDone) begin
        r_done = 1'b1; r_cyc = c; r_mis = oMisaligned; r_flt = oFault;
        r_rdata = oRdata; r_busy_done = oBusy; r_req_done = oMemReq;
        break;
      end
      if (oMemReq) begin
        if (!r_req_seen) begin
          r_be = oMemBe; r_we = oMemWe; r_addr = oMemAddr; r_wdata = oMemWdata;
        end else if (oMemBe !== r_be || oMemWe !== r_we || oMemAddr !== r_addr || oMemWdata !== r_wdata) begin
          r_unstable = 1'b1;
        end
        r_req_seen = 1'b1;
        if (reqc >= gd) begin
          iMemGnt = 1'b1; granted = 1'b1;
          if (same && ld) begin iMemRvalid = 1'b1; iMemRdata = rd; end
        end
        reqc++;
      end else if (granted) begin
        if (waitc >= rdl) begin iMemRvalid = 1'b1; iMemRdata = rd; end
        waitc++;
      end
    end
    r_reqc = reqc;
    iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0; iMemGnt = 1'b0; iMemRvalid = 1'b0;
  endtask

  task automatic check_txn(input string tag, input bit e_req, input bit e_mis, input bit e_flt,
                           input logic [3:0] e_be, input logic e_we, input logic [31:0] e_addr,
                           input logic [31:0] e_wd, input logic [31:0] e_rdata, input int e_cyc);
    chk($sformatf("%s_done", tag), 32'(r_done), 32'd1);
    chk($sformatf("%s_cycles", tag), 32'(r_cyc), 32'(e_cyc));
    chk($sformatf("%s_mis", tag), 32'(r_mis), 32'(e_mis));
    chk($sformatf("%s_flt", tag), 32'(r_flt), 32'(e_flt));
    chk($sformatf("%s_rdata", tag), r_rdata, e_rdata);
    chk($sformatf("%s_req_seen", tag), 32'(r_req_seen), 32'(e_req));
    chk($sformatf("%s_busy_accept", tag), 32'(r_busy_acc), 32'd1);
    chk($sformatf("%s_busy_done", tag), 32'(r_busy_done), 32'd0);
    if (e_req) begin
      chk($sformatf("%s_be", tag), 32'(r_be), 32'(e_be));
      chk($sformatf("%s_we", tag), 32'(r_we), 32'(e_we));
      chk($sformatf("%s_addr", tag), r_addr, e_addr);
      chk($sformatf("%s_stable", tag), 32'(r_unstable), 32'd0);
      if (e_we) chk($sformatf("%s_wdata", tag), r_wdata, e_wd);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk($sformatf("%s_done", tag), 32'(oDone), 32'd0);
    chk($sformatf("%s_busy", tag), 32'(oBusy), 32'd0);
    chk($sformatf("%s_rdata", tag), oRdata, 32'd0);
    chk($sformatf("%s_mis", tag), 32'(oMisaligned), 32'd0);
    chk($sformatf("%s_flt", tag), 32'(oFault), 32'd0);
    chk($sformatf("%s_req", tag), 32'(oMemReq), 32'd0);
    chk($sformatf("%s_we", tag), 32'(oMemWe), 32'd0);
    chk($sformatf("%s_be", tag), 32'(oMemBe), 32'd0);
    chk($sformatf("%s_addr", tag), oMemAddr, 32'd0);
    chk($sformatf("%s_wdata", tag), oMemWdata, 32'd0);
  endtask

  // Reference: access size in bytes, misalignment as addr mod size,
  // replication by multiplication, extension by masking.
  function automatic void model(
    input logic ld, input logic st, input logic [2:0] lt, input logic [1:0] ut,
    input logic [2:0] stt, input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] rd, input int gd, input int rdl, input bit same,
    output bit e_mis, output bit e_flt, output bit e_req, output logic [3:0] e_be,
    output logic [31:0] e_wd, output int e_cyc, output bit e_upd, output logic [31:0] e_rval);
    int size, off;
    bit sgn;
    logic [31:0] mask, x;
    size = 4; sgn = 1'b0; e_flt = 1'b0; e_mis = 1'b0;
    off = int'(addr % 32'd4);
    if (ld && st) e_flt = 1'b1;
    else if (ld) begin
      if ($countones({lt, ut}) != 1) e_flt = 1'b1;
      size = (lt[2] || ut[1]) ? 1 : (lt[1] || ut[0]) ? 2 : 4;
      sgn  = lt[2] || lt[1];
    end else begin
      if ($countones(stt) != 1) e_flt = 1'b1;
      size = stt[2] ? 1 : stt[1] ? 2 : 4;
    end
    if (!e_flt) e_mis = (off % size) != 0;
    e_req = !e_flt && !e_mis;
    e_be  = ld ? 4'hF : 4'(((1 << size) - 1) << off);
    e_wd  = (size == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
            (size == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
    mask  = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    x     = (rd >> (8 * off)) & mask;
    if (sgn && ((x & ((mask >> 1) + 32'h1)) != 32'h0)) x = x | ~mask;
    e_rval = x;
    e_upd  = e_req && ld;
    e_cyc  = !e_req ? 0 : (st || same) ? gd + 1 : gd + rdl + 2;
  endfunction

  typedef struct {
    logic ld; logic st; logic [2:0] lt; logic [1:0] ut; logic [2:0] stt;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rd; int gd; int rdl; bit same;
    bit e_mis; bit e_flt; logic [3:0] e_be; logic [31:0] e_wd; logic [31:0] e_rdata; int e_cyc;
  } vec_t;

  vec_t vt[14];
  logic [31:0] exp_hold;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e_mis, e_flt, e_req, e_upd, same;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_rval, addr;
    logic ld, st;
    logic [2:0] lt, stt;
    logic [1:0] ut;
    int e_cyc, k, gd, rdl;

    //          ld    st    lt      ut     stt     addr         wd            rd            gd rdl same  mis   flt   be       e_wd          e_rdata       cyc
    vt[0]  = '{1'b1, 1'b0, 3'b100, 2'b00, 3'b000, 32'h103, 32'h0,        32'h80FF_0000, 0, 0, 1'b0, 1'b0, 1'b0, 4'hF,    32'h0,        32'hFFFF_FF80, 2};
    vt[1]  = '{1'b1, 1'b0, 3'b000, 2'b01, 3'b000, 32'h102, 32'h0,        32'h9ABC_1234, 0, 0, 1'b0, 1'b0, 1'b0, 4'hF,    32'h0,        32'h0000_9ABC, 2};
    vt[2]  = '{1'b1, 1'b0, 3'b010, 2'b00, 3'b000, 32'h102, 32'h0,        32'h9ABC_1234, 1, 2, 1'b0, 1'b0, 1'b0, 4'hF,    32'h0,        32'hFFFF_9ABC, 5};
    vt[3]  = '{1'b0, 1'b1, 3'b000, 2'b00, 3'b100, 32'h101, 32'h0000_00A5, 32'h0,        0, 0, 1'b0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_9ABC, 1};
    vt[4]  = '{1'b0, 1'b1, 3'b000, 2'b00, 3'b001, 32'h102, 32'h1122_3344, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 4'h0,    32'h0,        32'hFFFF_9ABC, 0};
    vt[5]  = '{1'b1, 1'b0, 3'b010, 2'b00, 3'b000, 32'h101, 32'h0,        32'hFFFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 4'h0,    32'h0,        32'hFFFF_9ABC, 0};
    vt[6]  = '{1'b1, 1'b0, 3'b110, 2'b00, 3'b000, 32'h100, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'hFFFF_9ABC, 0};
    vt[7]  = '{1'b1, 1'b0, 3'b001, 2'b00, 3'b000, 32'h104, 32'h0,        32'h1234_5678, 2, 0, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0,        32'h1234_5678, 3};
    vt[8]  = '{1'b0, 1'b1, 3'b000, 2'b00, 3'b010, 32'h106, 32'hBEEF_1234, 32'h0,        0, 0, 1'b0, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 32'h1234_5678, 1};
    vt[9]  = '{1'b1, 1'b0, 3'b000, 2'b10, 3'b000, 32'h102, 32'h0,        32'h00C3_0000, 0, 1, 1'b0, 1'b0, 1'b0, 4'hF,    32'h0,        32'h0000_00C3, 3};
    vt[10] = '{1'b1, 1'b1, 3'b001, 2'b00, 3'b001, 32'h200, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0000_00C3, 0};
    vt[11] = '{1'b0, 1'b1, 3'b000, 2'b00, 3'b001, 32'h208, 32'hDEAD_BEEF, 32'h0,        3, 0, 1'b0, 1'b0, 1'b0, 4'hF,    32'hDEAD_BEEF, 32'h0000_00C3, 4};
    vt[12] = '{1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 32'h0,   32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 1'b1, 4'h0,    32'h0,        32'h0000_00C3, 0};
    vt[13] = '{1'b1, 1'b0, 3'b100, 2'b00, 3'b000, 32'h101, 32'h0,        32'h0000_7F00, 0, 0, 1'b0, 1'b0, 1'b0, 4'hF,    32'h0,        32'h0000_007F, 2};

    iRst = 1'b1; iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0;
    iLoadTypeBHW = 3'b000; iULoadTypeBH = 2'b00; iStoreTypeBHW = 3'b000;
    iAddr = 32'h0; iWdata = 32'h0; iMemGnt = 1'b0; iMemRvalid = 1'b0; iMemRdata = 32'h0;
    repeat (2) @(negedge iClk);
    check_quiet("reset");
    iRst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      run_access(vt[i].ld, vt[i].st, vt[i].lt, vt[i].ut, vt[i].stt, vt[i].addr, vt[i].wd,
                 vt[i].rd, vt[i].gd, vt[i].rdl, vt[i].same);
      check_txn($sformatf("vec%0d", i), !vt[i].e_mis && !vt[i].e_flt, vt[i].e_mis, vt[i].e_flt,
                vt[i].e_be, vt[i].st, {vt[i].addr[31:2], 2'b00}, vt[i].e_wd, vt[i].e_rdata, vt[i].e_cyc);
    end
    exp_hold = vt[13].e_rdata;

    // Grant withheld: fault after exactly TO cycles in REQ.
    run_access(1'b1, 1'b0, 3'b001, 2'b00, 3'b000, 32'h300, 32'h0, 32'h5555_AAAA, 1000, 0, 1'b0);
    check_txn("timeout", 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 32'h300, 32'h0, exp_hold, TO);
    chk("timeout_req_cycles", 32'(r_reqc), 32'(TO));
    chk("timeout_req_in_done", 32'(r_req_done), 32'd0);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    @(negedge iClk);
    iValid = 1'b1; iLoad = 1'b1; iLoadTypeBHW = 3'b001; iAddr = 32'h40;
    @(negedge iClk);
    iValid = 1'b0; iLoad = 1'b0;
    chk("rstwait_req", 32'(oMemReq), 32'd1);
    iMemGnt = 1'b1;
    @(negedge iClk);
    iMemGnt = 1'b0;
    chk("rstwait_busy_wait", 32'(oBusy), 32'd1);
    chk("rstwait_noreq_wait", 32'(oMemReq), 32'd0);
    iRst = 1'b1;
    #2 iRst = 1'b0;
    @(negedge iClk);
    iMemRvalid = 1'b1; iMemRdata = 32'hCAFE_F00D;
    @(negedge iClk);
    iMemRvalid = 1'b0;
    check_quiet("rstwait");
    @(negedge iClk);
    chk("rstwait_still_idle", 32'(oDone), 32'd0);
    exp_hold = 32'h0;
    run_access(1'b1, 1'b0, 3'b001, 2'b00, 3'b000, 32'h44, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0);
    check_txn("post_rst", 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h44, 32'h0, 32'h0BAD_CAFE, 2);
    exp_hold = 32'h0BAD_CAFE;

    // Randomized accesses against the reference model.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      ld = 1'b0; st = 1'b0; lt = 3'b000; ut = 2'b00; stt = 3'b000;
      case (k)
        0: begin ld = 1'b1; lt = 3'b100; end
        1: begin ld = 1'b1; lt = 3'b010; end
        2: begin ld = 1'b1; lt = 3'b001; end
        3: begin ld = 1'b1; ut = 2'b10; end
        4: begin ld = 1'b1; ut = 2'b01; end
        5: begin st = 1'b1; stt = 3'b100; end
        6: begin st = 1'b1; stt = 3'b010; end
        7: begin st = 1'b1; stt = 3'b001; end
        8: begin
          ld = 1'($urandom); st = ld ? 1'($urandom) : 1'b1;
          lt = 3'($urandom); ut = 2'($urandom); stt = 3'($urandom);
        end
        default: begin ld = 1'b1; lt = 3'b001; end
      endcase
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (k == 1 || k == 4 || k == 6) addr[0] = 1'b0;
        else if (k == 2 || k == 7 || k == 9) addr[1:0] = 2'b00;
      end
      gd = $urandom_range(0, 4); rdl = $urandom_range(0, 4); same = 1'($urandom);
      e_wd = $urandom;
      e_rval = $urandom;
      begin
        logic [31:0] wd, rd;
        wd = e_wd; rd = e_rval;
        model(ld, st, lt, ut, stt, addr, wd, rd, gd, rdl, same,
              e_mis, e_flt, e_req, e_be, e_wd, e_cyc, e_upd, e_rval);
        run_access(ld, st, lt, ut, stt, addr, wd, rd, gd, rdl, same);
      end
      if (e_upd) exp_hold = e_rval;
      check_txn($sformatf("rnd%0d", i), e_req, e_mis, e_flt, e_be, st, {addr[31:2], 2'b00},
                e_wd, exp_hold, e_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
